muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the execute stage, fed by the ID/EX latch outputs alongside the ALU. It runs MULT, MULTU, DIV and DIVU over 32 iterations and owns the architectural HI/LO registers, which MFHI/MFLO read and MTHI/MTLO write. While an operation is in flight it raises `busy`, and the hazard logic stalls IF/ID/EX on that signal. A flush from branch resolution aborts an operation that has not yet committed.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/muldiv_sign_fix.sv | 43 ++++
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
package cpu_types_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    OpMult  = 2'd0,
    OpMultu = 2'd1,
    OpDiv   = 2'd2,
    OpDivu  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } muldiv_state_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == OpMult) || (op == OpDiv);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Applies operand-sign correction to the unsigned magnitude result and
// splits it into HI/LO.
module muldiv_sign_fix
  import cpu_types_pkg::*;
(
  input  muldiv_op_t  op,
  input  logic        sign_a,
  input  logic        sign_b,
  input  logic        div_zero,
  input  logic [63:0] raw,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  always_comb begin
    hi = raw[63:32];
    lo = raw[31:0];
    unique case (op)
      OpMult: begin
        if (sign_a ^ sign_b) begin
          {hi, lo} = -raw;
        end
      end
      OpDiv: begin
        // Divide by zero yields all-ones; the magnitude quotient is already
        // all-ones, but the dividend sign must not flip it.
        if (div_zero) begin
          lo = '1;
        end else if (sign_a ^ sign_b) begin
          lo = -raw[31:0];
        end
        if (sign_a) begin
          hi = -raw[63:32];
        end
      end
      OpMultu, OpDivu: begin
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit owning the HI/LO registers;
// raises busy for the hazard unit while an operation is in flight.
module muldiv_unit
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] mt_data,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  muldiv_state_t state_q, state_d;
  muldiv_op_t    op_q, op_d, op_in;
  logic [4:0]    cnt_q, cnt_d;
  logic [63:0]   acc_q, acc_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic          sa_q, sa_d;
  logic          sb_q, sb_d;
  logic          div0_q, div0_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          done_q, done_d;

  logic          accept;
  logic          in_signed;
  logic [32:0]   mul_sum;
  logic [63:0]   mul_next;
  logic [32:0]   div_shift;
  logic [33:0]   div_trial;
  logic          div_ge;
  logic [63:0]   div_next;
  logic [31:0]   fix_hi;
  logic [31:0]   fix_lo;

  assign op_in = muldiv_op_t'(op);

  // The done cycle still holds the same stalled instruction in ID/EX, so it
  // must not be re-accepted while it advances.
  assign accept    = start && (state_q == StIdle) && !flush && !done_q;
  assign in_signed = op_is_signed(op_in);

  // Shift-add: add the multiplicand into the upper half, then shift the
  // 65-bit sum right by one.
  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Restoring step: acc holds {remainder, quotient}, dividend bits come
  // from the MSB of a_q.
  assign div_shift = {acc_q[63:32], a_q[31]};
  assign div_trial = {1'b0, div_shift} - {2'b00, b_q};
  assign div_ge    = !div_trial[33];
  assign div_next  = {(div_ge ? div_trial[31:0] : div_shift[31:0]), acc_q[30:0], div_ge};

  muldiv_sign_fix u_sign_fix (
    .op       (op_q),
    .sign_a   (sa_q),
    .sign_b   (sb_q),
    .div_zero (div0_q),
    .raw      (acc_q),
    .hi       (fix_hi),
    .lo       (fix_lo)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mthi) begin
          hi_d = mt_data;
        end
        if (mtlo) begin
          lo_d = mt_data;
        end
        if (accept) begin
          op_d    = op_in;
          sa_d    = in_signed && rs_val[31];
          sb_d    = in_signed && rt_val[31];
          a_d     = sa_d ? -rs_val : rs_val;
          b_d     = sb_d ? -rt_val : rt_val;
          div0_d  = (rt_val == 32'd0);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          if (op_is_div(op_q)) begin
            acc_d = div_next;
            a_d   = {a_q[30:0], 1'b0};
          end else begin
            acc_d = mul_next;
            b_d   = {1'b0, b_q[31:1]};
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = StFix;
          end
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      op_q    <= OpMult;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = accept || (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

  logic        CLK;
  logic        nRST;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] mt_data;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] MULT  = 2'd0;
  localparam logic [1:0] MULTU = 2'd1;
  localparam logic [1:0] DIV   = 2'd2;
  localparam logic [1:0] DIVU  = 2'd3;

  muldiv_unit dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .start   (start),
    .op      (op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .mthi    (mthi),
    .mtlo    (mtlo),
    .mt_data (mt_data),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Holds start like a stalled ID/EX latch until busy drops; returns the
  // number of busy cycles and done in the first non-busy cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic done_seen);
    @(negedge CLK);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    #1;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge CLK);
      #1;
    end
    done_seen = done;
    start = 1'b0;
  endtask

  task automatic test_reset;
    nRST = 1'b0; start = 0; op = 0; rs_val = 0; rt_val = 0;
    mthi = 0; mtlo = 0; mt_data = 0; flush = 0;
    #12;
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_mult_small;
    int cyc; logic d;
    run_op(MULT, 32'd7, 32'd6, cyc, d);
    total++; if (cyc !== 34) begin bad++; $display("FAIL mult7x6_busy_cycles got=%0d exp=34", cyc); end
    total++; if (d !== 1'b1) begin bad++; $display("FAIL mult7x6_done got=%b exp=1", d); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL mult7x6_hi got=%h exp=00000000", hi); end
    total++; if (lo !== 32'h2A) begin bad++; $display("FAIL mult7x6_lo got=%h exp=0000002a", lo); end
    @(negedge CLK); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_pulse_width got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_after_done got=%b exp=0", busy); end
  endtask

  task automatic test_mult_signs;
    int cyc; logic d;
    run_op(MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, d);
    total++; if ({hi, lo} !== 64'h00000000_00000001) begin
      bad++; $display("FAIL mult_neg1_sq got=%h_%h exp=00000000_00000001", hi, lo); end
    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, d);
    total++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin
      bad++; $display("FAIL multu_max_sq got=%h_%h exp=fffffffe_00000001", hi, lo); end
    run_op(MULT, 32'hFFFFFFFD, 32'd5, cyc, d);
    total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin
      bad++; $display("FAIL mult_neg3x5 got=%h_%h exp=ffffffff_fffffff1", hi, lo); end
  endtask

  task automatic test_div;
    int cyc; logic d;
    run_op(DIV, 32'hFFFFFFF9, 32'd2, cyc, d);
    total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_m7_2_lo got=%h exp=fffffffd", lo); end
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_m7_2_hi got=%h exp=ffffffff", hi); end
    run_op(DIVU, 32'd100, 32'd7, cyc, d);
    total++; if (lo !== 32'd14) begin bad++; $display("FAIL divu_100_7_lo got=%h exp=0000000e", lo); end
    total++; if (hi !== 32'd2) begin bad++; $display("FAIL divu_100_7_hi got=%h exp=00000002", hi); end
    run_op(DIV, 32'h80000000, 32'hFFFFFFFF, cyc, d);
    total++; if ({hi, lo} !== 64'h00000000_80000000) begin
      bad++; $display("FAIL div_overflow got=%h_%h exp=00000000_80000000", hi, lo); end
    run_op(DIVU, 32'hFFFFFFFF, 32'h00010000, cyc, d);
    total++; if ({hi, lo} !== 64'h0000FFFF_0000FFFF) begin
      bad++; $display("FAIL divu_big got=%h_%h exp=0000ffff_0000ffff", hi, lo); end
  endtask

  task automatic test_div_zero;
    int cyc; logic d;
    run_op(DIVU, 32'd5, 32'd0, cyc, d);
    total++; if (cyc !== 34) begin bad++; $display("FAIL divu_zero_cycles got=%0d exp=34", cyc); end
    total++; if (lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL divu_zero_lo got=%h exp=ffffffff", lo); end
    total++; if (hi !== 32'd5) begin bad++; $display("FAIL divu_zero_hi got=%h exp=00000005", hi); end
    run_op(DIV, 32'hFFFFFFF8, 32'd0, cyc, d);
    total++; if ({hi, lo} !== 64'hFFFFFFF8_FFFFFFFF) begin
      bad++; $display("FAIL div_zero_neg got=%h_%h exp=fffffff8_ffffffff", hi, lo); end
  endtask

  task automatic test_mt;
    @(negedge CLK);
    mthi = 1'b1; mtlo = 1'b1; mt_data = 32'h5A5A0000;
    @(negedge CLK);
    mthi = 1'b0; mtlo = 1'b0;
    #1;
    total++; if ({hi, lo} !== 64'h5A5A0000_5A5A0000) begin
      bad++; $display("FAIL mt_both got=%h_%h exp=5a5a0000_5a5a0000", hi, lo); end
    @(negedge CLK);
    mthi = 1'b1; mt_data = 32'hA5A5A5A5;
    @(negedge CLK);
    mthi = 1'b0;
    #1;
    total++; if ({hi, lo} !== 64'hA5A5A5A5_5A5A0000) begin
      bad++; $display("FAIL mthi_only got=%h_%h exp=a5a5a5a5_5a5a0000", hi, lo); end
  endtask

  task automatic test_flush;
    logic saw_done;
    saw_done = 1'b0;
    @(negedge CLK);
    start = 1'b1; op = MULT; rs_val = 32'd3; rt_val = 32'd3;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      mtlo = (i == 5);
      mt_data = 32'h0000FFFF;
      if (done) saw_done = 1'b1;
    end
    mtlo = 1'b0;
    flush = 1'b1;
    @(negedge CLK); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
    start = 1'b0; flush = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done = 1'b1;
      @(negedge CLK);
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL flush_no_done got=%b exp=0", saw_done); end
    total++; if ({hi, lo} !== 64'hA5A5A5A5_5A5A0000) begin
      bad++; $display("FAIL flush_hilo got=%h_%h exp=a5a5a5a5_5a5a0000", hi, lo); end
  endtask

  task automatic test_start_flush_idle;
    @(negedge CLK);
    start = 1'b1; flush = 1'b1; op = MULT; rs_val = 32'd9; rt_val = 32'd9;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_flush_busy got=%b exp=0", busy); end
    @(negedge CLK);
    start = 1'b0; flush = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_flush_state got=%b exp=0", busy); end
  endtask

  task automatic test_mt_with_start;
    int cyc;
    @(negedge CLK);
    start = 1'b1; op = MULTU; rs_val = 32'd2; rt_val = 32'd3;
    mthi = 1'b1; mt_data = 32'h12345678;
    @(negedge CLK);
    mthi = 1'b0;
    #1;
    total++; if (hi !== 32'h12345678) begin bad++; $display("FAIL mt_with_start_hi got=%h exp=12345678", hi); end
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(negedge CLK);
      #1;
    end
    start = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL mt_with_start_done got=%b exp=1", done); end
    total++; if ({hi, lo} !== 64'h00000000_00000006) begin
      bad++; $display("FAIL mt_with_start_commit got=%h_%h exp=00000000_00000006", hi, lo); end
  endtask

  task automatic test_reset_mid_op;
    int cyc; logic d;
    @(negedge CLK);
    start = 1'b1; op = MULT; rs_val = 32'd5; rt_val = 32'd5;
    for (int i = 0; i < 20; i++) @(negedge CLK);
    start = 1'b0;
    nRST = 1'b0;
    #1;
    total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL rst_mid_hilo got=%h_%h exp=0", hi, lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    @(negedge CLK);
    nRST = 1'b1;
    run_op(MULT, 32'd2, 32'd2, cyc, d);
    total++; if (cyc !== 34) begin bad++; $display("FAIL after_rst_cycles got=%0d exp=34", cyc); end
    total++; if ({hi, lo} !== 64'h00000000_00000004) begin
      bad++; $display("FAIL after_rst_mult got=%h_%h exp=00000000_00000004", hi, lo); end
  endtask

  initial begin
    test_reset;
    test_mult_small;
    test_mult_signs;
    test_div;
    test_div_zero;
    test_mt;
    test_flush;
    test_start_flush_idle;
    test_mt_with_start;
    test_reset_mid_op;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
